// File: rtl/ofmap_wr_addrgen.sv
// Output feature-map write address generator: accepts one result per handshake and
// issues a registered write at BASE_ADDR + f*W*W + i*W + j, with optional ReLU clamp.
module ofmap_wr_addrgen #(
   parameter int unsigned OUT_FEATURE_WIDTH      = 24,
   parameter int unsigned NUM_ONEMULT            = 2,
   parameter int unsigned OUT_FEATURE_ADDR_WIDTH = 11,
   parameter int unsigned DATA_WIDTH             = 16,
   parameter int unsigned BASE_ADDR              = 0,
   parameter int unsigned RELU_EN                = 1,
   parameter int unsigned ROW_WIDTH              = 5,
   parameter int unsigned MAP_WIDTH              = 2
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              start,
   input  logic                              in_valid,
   input  logic [DATA_WIDTH-1:0]             in_data,
   output logic                              in_ready,
   input  logic                              mem_stall,
   output logic                              wr_en,
   output logic [OUT_FEATURE_ADDR_WIDTH-1:0] wr_addr,
   output logic [DATA_WIDTH-1:0]             wr_data,
   output logic                              map_last,
   output logic                              done
);

   localparam int unsigned AW = OUT_FEATURE_ADDR_WIDTH;
   localparam logic [ROW_WIDTH-1:0] LAST_POS  = ROW_WIDTH'(OUT_FEATURE_WIDTH - 1);
   localparam logic [MAP_WIDTH-1:0] LAST_MAP  = MAP_WIDTH'(NUM_ONEMULT - 1);
   localparam logic [AW-1:0]        BASE      = AW'(BASE_ADDR);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t                state, state_next;
   logic [ROW_WIDTH-1:0]  row, col;
   logic [MAP_WIDTH-1:0]  map;
   logic [AW-1:0]         addr;
   logic                  accept, col_end, map_end, run_end, load;
   logic [DATA_WIDTH-1:0] relu_data;

   assign in_ready  = (state == RUN) && !mem_stall;
   assign accept    = in_valid && in_ready;
   assign col_end   = (col == LAST_POS);
   assign map_end   = col_end && (row == LAST_POS);
   assign run_end   = map_end && (map == LAST_MAP);
   assign load      = start && (state != RUN);
   assign relu_data = ((RELU_EN != 0) && in_data[DATA_WIDTH-1]) ? '0 : in_data;

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = RUN;
         RUN:     if (accept && run_end) state_next = DONE;
         DONE:    if (start) state_next = RUN;
         default: state_next = IDLE;
      endcase
   end

   // Pixel position counters; linear addr avoids a W*W multiply per write.
   always_ff @(posedge clk) begin
      if (reset) begin
         row  <= '0;
         col  <= '0;
         map  <= '0;
         addr <= '0;
      end else if (load) begin
         row  <= '0;
         col  <= '0;
         map  <= '0;
         addr <= BASE;
      end else if (accept) begin
         addr <= addr + AW'(1);
         if (col_end) begin
            col <= '0;
            if (row == LAST_POS) begin
               row <= '0;
               map <= run_end ? '0 : map + MAP_WIDTH'(1);
            end else begin
               row <= row + ROW_WIDTH'(1);
            end
         end else begin
            col <= col + ROW_WIDTH'(1);
         end
      end
   end

   // Write port registers; address and data hold between writes.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_en    <= 1'b0;
         wr_addr  <= '0;
         wr_data  <= '0;
         map_last <= 1'b0;
         done     <= 1'b0;
      end else begin
         wr_en    <= accept;
         map_last <= accept && map_end;
         done     <= (state_next == DONE);
         if (accept) begin
            wr_addr <= addr;
            wr_data <= relu_data;
         end
      end
   end

endmodule

// File: tb/tb_ofmap_wr_addrgen.sv
// Randomized bench for ofmap_wr_addrgen: three instances (ReLU on, ReLU off, offset base)
// share stimulus and are checked against a pixel-index reference model.
module tb_ofmap_wr_addrgen;

   localparam int unsigned W    = 4;
   localparam int unsigned NM   = 2;
   localparam int unsigned AW   = 11;
   localparam int unsigned DW   = 16;
   localparam int unsigned NPIX = W * W * NM;
   localparam int unsigned BASEC = 100;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset, start, in_valid, mem_stall;
   logic [DW-1:0] in_data;
   logic          in_ready_a, wr_en_a, map_last_a, done_a;
   logic [AW-1:0] wr_addr_a;
   logic [DW-1:0] wr_data_a;
   logic          in_ready_b, wr_en_b, map_last_b, done_b;
   logic [AW-1:0] wr_addr_b;
   logic [DW-1:0] wr_data_b;
   logic          in_ready_c, wr_en_c, map_last_c, done_c;
   logic [AW-1:0] wr_addr_c;
   logic [DW-1:0] wr_data_c;

   ofmap_wr_addrgen #(.OUT_FEATURE_WIDTH(W), .NUM_ONEMULT(NM), .OUT_FEATURE_ADDR_WIDTH(AW),
      .DATA_WIDTH(DW), .BASE_ADDR(0), .RELU_EN(1), .ROW_WIDTH(5), .MAP_WIDTH(2)) dut_a (
      .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready_a), .mem_stall(mem_stall), .wr_en(wr_en_a), .wr_addr(wr_addr_a),
      .wr_data(wr_data_a), .map_last(map_last_a), .done(done_a));

   ofmap_wr_addrgen #(.OUT_FEATURE_WIDTH(W), .NUM_ONEMULT(NM), .OUT_FEATURE_ADDR_WIDTH(AW),
      .DATA_WIDTH(DW), .BASE_ADDR(0), .RELU_EN(0), .ROW_WIDTH(5), .MAP_WIDTH(2)) dut_b (
      .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready_b), .mem_stall(mem_stall), .wr_en(wr_en_b), .wr_addr(wr_addr_b),
      .wr_data(wr_data_b), .map_last(map_last_b), .done(done_b));

   ofmap_wr_addrgen #(.OUT_FEATURE_WIDTH(W), .NUM_ONEMULT(NM), .OUT_FEATURE_ADDR_WIDTH(AW),
      .DATA_WIDTH(DW), .BASE_ADDR(BASEC), .RELU_EN(1), .ROW_WIDTH(5), .MAP_WIDTH(2)) dut_c (
      .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready_c), .mem_stall(mem_stall), .wr_en(wr_en_c), .wr_addr(wr_addr_c),
      .wr_data(wr_data_c), .map_last(map_last_c), .done(done_c));

   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic          last;
      logic          done;
      int            cyc;
   } wr_t;

   wr_t           qa[$];
   logic [DW-1:0] qb[$];
   logic [AW-1:0] qc[$];
   logic [DW-1:0] exp_in[$];
   bit            rdy_q[$];
   bit            stall_q[$];
   int            checks = 0;
   int            failures = 0;
   int            cyc = 0;

   always @(posedge clk) cyc++;

   // Write capture only; all judging happens in the test tasks.
   always @(negedge clk) begin
      wr_t w;
      if (wr_en_a === 1'b1) begin
         w.addr = wr_addr_a; w.data = wr_data_a; w.last = map_last_a;
         w.done = done_a;    w.cyc  = cyc;
         qa.push_back(w);
      end
      if (wr_en_b === 1'b1) qb.push_back(wr_data_b);
      if (wr_en_c === 1'b1) qc.push_back(wr_addr_c);
   end

   function automatic logic [DW-1:0] relu(input logic [DW-1:0] x);
      return ($signed(x) < 0) ? '0 : x;
   endfunction

   // Stimulus: start (with a non-consumable in_valid beside it), then feed until
   // stop_after results have been accepted; a short run ends with reset.
   task automatic run_pixels(input int duty, input int mode, input int stall_after,
                             input int stall_len, input bit start_noise, input int stop_after);
      int            acc = 0;
      int            guard = 0;
      int            stall_rem;
      bit            v, st;
      logic [DW-1:0] d;
      logic [DW-1:0] pat[4] = '{16'hFFFB, 16'h0000, 16'h0007, 16'h8000};
      stall_rem = stall_len;
      qa.delete(); qb.delete(); qc.delete(); exp_in.delete(); rdy_q.delete(); stall_q.delete();
      start = 1'b1; in_valid = 1'b1; in_data = 16'h7777; mem_stall = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      while (acc < stop_after && guard < 4000) begin
         guard++;
         st = (stall_after >= 0) && (acc == stall_after) && (stall_rem > 0);
         if (st) stall_rem--;
         v = (duty >= 100) || (int'($urandom_range(99)) < duty);
         case (mode)
            1:       d = DW'(acc);
            2:       d = (acc < 4) ? pat[acc] : DW'($urandom);
            default: d = DW'($urandom);
         endcase
         in_valid = v; in_data = d; mem_stall = st;
         start = start_noise && ($urandom_range(3) == 0);
         #1;
         rdy_q.push_back(in_ready_a);
         stall_q.push_back(st);
         @(posedge clk); #1;
         if (v && !st) begin
            exp_in.push_back(d);
            acc++;
         end
      end
      in_valid = 1'b0; start = 1'b0; mem_stall = 1'b0;
      if (stop_after < int'(NPIX)) begin
         reset = 1'b1; in_valid = 1'b1;
         @(posedge clk); #1;
         reset = 1'b0; in_valid = 1'b0;
      end
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; in_valid = 1'b0; mem_stall = 1'b0; in_data = '0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (wr_en_a !== 1'b0) begin failures++; $display("FAIL reset_wr_en got=%b exp=0", wr_en_a); end
      checks++; if (wr_addr_a !== '0) begin failures++; $display("FAIL reset_wr_addr got=%0d exp=0", wr_addr_a); end
      checks++; if (wr_addr_c !== '0) begin failures++; $display("FAIL reset_wr_addr_c got=%0d exp=0", wr_addr_c); end
      checks++; if (wr_data_a !== '0) begin failures++; $display("FAIL reset_wr_data got=%0d exp=0", wr_data_a); end
      checks++; if (map_last_a !== 1'b0) begin failures++; $display("FAIL reset_map_last got=%b exp=0", map_last_a); end
      checks++; if (done_a !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done_a); end
      checks++; if (in_ready_a !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", in_ready_a); end
      reset = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      checks++; if (in_ready_a !== 1'b0) begin failures++; $display("FAIL idle_in_ready got=%b exp=0", in_ready_a); end
      checks++; if (wr_en_a !== 1'b0) begin failures++; $display("FAIL idle_wr_en got=%b exp=0", wr_en_a); end
      in_valid = 1'b0;
   endtask

   task automatic test_full_run();
      run_pixels(100, 1, -1, 0, 1'b0, int'(NPIX));
      checks++; if (qa.size() != NPIX) begin failures++; $display("FAIL full_count got=%0d exp=%0d", qa.size(), NPIX); end
      for (int i = 0; i < qa.size() && i < int'(NPIX); i++) begin
         checks++; if (qa[i].addr !== AW'(i)) begin failures++; $display("FAIL full_addr[%0d] got=%0d exp=%0d", i, qa[i].addr, i); end
         checks++; if (qa[i].data !== DW'(i)) begin failures++; $display("FAIL full_data[%0d] got=%0d exp=%0d", i, qa[i].data, i); end
         checks++; if (qa[i].last !== ((i % (W*W)) == W*W-1)) begin failures++; $display("FAIL full_map_last[%0d] got=%b", i, qa[i].last); end
         checks++; if (qa[i].done !== (i == int'(NPIX) - 1)) begin failures++; $display("FAIL full_done[%0d] got=%b", i, qa[i].done); end
         checks++; if (qa[i].cyc != qa[0].cyc + i) begin failures++; $display("FAIL full_cycle[%0d] got=%0d exp=%0d", i, qa[i].cyc, qa[0].cyc + i); end
      end
      checks++; if (qc.size() != NPIX) begin failures++; $display("FAIL full_count_c got=%0d exp=%0d", qc.size(), NPIX); end
      for (int i = 0; i < qc.size() && i < int'(NPIX); i++) begin
         checks++; if (qc[i] !== AW'(BASEC + i)) begin failures++; $display("FAIL full_addr_c[%0d] got=%0d exp=%0d", i, qc[i], BASEC + i); end
      end
      checks++; if (in_ready_a !== 1'b0) begin failures++; $display("FAIL full_ready_after got=%b exp=0", in_ready_a); end
      checks++; if (done_a !== 1'b1) begin failures++; $display("FAIL full_done_after got=%b exp=1", done_a); end
   endtask

   task automatic test_relu();
      run_pixels(100, 2, -1, 0, 1'b0, int'(NPIX));
      checks++; if (qa.size() != NPIX || qb.size() != NPIX || exp_in.size() != NPIX) begin
         failures++; $display("FAIL relu_count got=%0d/%0d exp=%0d", qa.size(), qb.size(), NPIX); end
      for (int i = 0; i < qa.size() && i < qb.size() && i < exp_in.size(); i++) begin
         checks++; if (qa[i].data !== relu(exp_in[i])) begin failures++; $display("FAIL relu_on[%0d] got=%0d exp=%0d", i, $signed(qa[i].data), $signed(relu(exp_in[i]))); end
         checks++; if (qb[i] !== exp_in[i]) begin failures++; $display("FAIL relu_off[%0d] got=%0d exp=%0d", i, $signed(qb[i]), $signed(exp_in[i])); end
      end
   endtask

   task automatic test_stall();
      run_pixels(100, 0, 5, 3, 1'b0, int'(NPIX));
      for (int k = 0; k < rdy_q.size(); k++) begin
         checks++; if (rdy_q[k] != !stall_q[k]) begin failures++; $display("FAIL stall_ready[%0d] got=%0d exp=%0d", k, rdy_q[k], !stall_q[k]); end
      end
      checks++; if (qa.size() != NPIX) begin failures++; $display("FAIL stall_count got=%0d exp=%0d", qa.size(), NPIX); end
      if (qa.size() > 5) begin
         checks++; if (qa[5].addr !== AW'(5)) begin failures++; $display("FAIL stall_resume_addr got=%0d exp=5", qa[5].addr); end
         checks++; if (qa[5].cyc - qa[4].cyc != 4) begin failures++; $display("FAIL stall_gap got=%0d exp=4", qa[5].cyc - qa[4].cyc); end
      end
      for (int i = 0; i < qa.size(); i++) begin
         checks++; if (qa[i].addr !== AW'(i)) begin failures++; $display("FAIL stall_addr[%0d] got=%0d exp=%0d", i, qa[i].addr, i); end
      end
   endtask

   task automatic test_random_gaps();
      run_pixels(50, 0, -1, 0, 1'b0, int'(NPIX));
      checks++; if (qa.size() != NPIX) begin failures++; $display("FAIL gaps_count got=%0d exp=%0d", qa.size(), NPIX); end
      for (int i = 0; i < qa.size() && i < exp_in.size(); i++) begin
         checks++; if (qa[i].addr !== AW'(i)) begin failures++; $display("FAIL gaps_addr[%0d] got=%0d exp=%0d", i, qa[i].addr, i); end
         checks++; if (qa[i].data !== relu(exp_in[i])) begin failures++; $display("FAIL gaps_data[%0d] got=%0d exp=%0d", i, qa[i].data, relu(exp_in[i])); end
      end
   endtask

   task automatic test_reset_mid_run();
      run_pixels(100, 0, -1, 0, 1'b0, 10);
      checks++; if (qa.size() != 10) begin failures++; $display("FAIL midrst_count got=%0d exp=10", qa.size()); end
      checks++; if (wr_en_a !== 1'b0) begin failures++; $display("FAIL midrst_wr_en got=%b exp=0", wr_en_a); end
      checks++; if (in_ready_a !== 1'b0) begin failures++; $display("FAIL midrst_in_ready got=%b exp=0", in_ready_a); end
      checks++; if (done_a !== 1'b0) begin failures++; $display("FAIL midrst_done got=%b exp=0", done_a); end
      checks++; if (wr_addr_a !== '0) begin failures++; $display("FAIL midrst_wr_addr got=%0d exp=0", wr_addr_a); end
      run_pixels(100, 1, -1, 0, 1'b0, int'(NPIX));
      checks++; if (qa.size() != NPIX) begin failures++; $display("FAIL midrst_rerun_count got=%0d exp=%0d", qa.size(), NPIX); end
      for (int i = 0; i < qa.size(); i++) begin
         checks++; if (qa[i].addr !== AW'(i)) begin failures++; $display("FAIL midrst_rerun_addr[%0d] got=%0d exp=%0d", i, qa[i].addr, i); end
      end
   endtask

   task automatic test_restart();
      for (int pass = 0; pass < 2; pass++) begin
         run_pixels(70, 0, -1, 0, 1'b1, int'(NPIX));
         checks++; if (qc.size() != NPIX) begin failures++; $display("FAIL restart_count[%0d] got=%0d exp=%0d", pass, qc.size(), NPIX); end
         for (int i = 0; i < qc.size(); i++) begin
            checks++; if (qc[i] !== AW'(BASEC + i)) begin failures++; $display("FAIL restart_addr_c[%0d][%0d] got=%0d exp=%0d", pass, i, qc[i], BASEC + i); end
         end
         for (int i = 0; i < qa.size(); i++) begin
            checks++; if (qa[i].addr !== AW'(i)) begin failures++; $display("FAIL restart_addr_a[%0d][%0d] got=%0d exp=%0d", pass, i, qa[i].addr, i); end
         end
         checks++; if (done_c !== 1'b1) begin failures++; $display("FAIL restart_done[%0d] got=%b exp=1", pass, done_c); end
      end
   endtask

   initial begin
      test_reset();
      test_full_run();
      test_relu();
      test_stall();
      test_random_gaps();
      test_reset_mid_run();
      test_restart();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
